// File: rtl/sorted_tbl.sv
// sorted_tbl: N-entry ascending key-sorted table with INSERT / DELETE-by-key / POP-head.
// Entry 0 always holds the smallest key; validity is a thermometer from entry 0.
// One registered response per accepted command, held until i_rsp_rdy.
module sorted_tbl #(
    parameter int N     = 8,
    parameter int KEY_W = 16,
    parameter int VAL_W = 32
) (
    input  logic                   clk,
    input  logic                   arst,
    input  logic                   i_cmd_vld,
    input  logic [1:0]             i_cmd_op,
    input  logic [KEY_W-1:0]       i_cmd_key,
    input  logic [VAL_W-1:0]       i_cmd_val,
    output logic                   o_cmd_rdy,
    output logic                   o_rsp_vld,
    input  logic                   i_rsp_rdy,
    output logic                   o_rsp_hit,
    output logic [KEY_W-1:0]       o_rsp_key,
    output logic [VAL_W-1:0]       o_rsp_val,
    output logic                   o_full,
    output logic                   o_empty,
    output logic [$clog2(N+1)-1:0] o_cnt
);

    typedef enum logic [1:0] {
        OP_INSERT = 2'd0,
        OP_DELETE = 2'd1,
        OP_POP    = 2'd2,
        OP_NOP    = 2'd3
    } op_t;

    typedef enum logic {
        RSP_IDLE,
        RSP_VLD
    } rsp_state_t;

    logic [KEY_W-1:0] key_q   [N];
    logic [VAL_W-1:0] val_q   [N];
    logic [KEY_W-1:0] nxt_key [N];
    logic [VAL_W-1:0] nxt_val [N];
    logic [N-1:0]     vld_q;
    logic [N-1:0]     vld_n;
    logic [N-1:0]     pivot;
    logic [N-1:0]     at_or_above;
    logic [KEY_W-1:0] sel_key;
    logic [VAL_W-1:0] sel_val;
    logic             rsp_hit_n;
    logic [KEY_W-1:0] rsp_key_n;
    logic [VAL_W-1:0] rsp_val_n;
    logic             accept;
    logic             change;
    op_t              op;
    rsp_state_t       rsp_state;

    assign op        = op_t'(i_cmd_op);
    assign o_cmd_rdy = !o_rsp_vld | i_rsp_rdy;
    assign accept    = i_cmd_vld & o_cmd_rdy;
    assign change    = accept & (|pivot);

    // Pivot selection: insertion slot, first matching key, or the head entry.
    always_comb begin
        logic found;
        pivot = '0;
        found = 1'b0;
        case (op)
            OP_INSERT: begin
                if (!o_full) begin
                    // Strict '>' places equal keys after existing ones.
                    for (int unsigned i = 0; i < N; i++) begin
                        if (!found && (!vld_q[i] || key_q[i] > i_cmd_key)) begin
                            pivot[i] = 1'b1;
                            found    = 1'b1;
                        end
                    end
                end
            end
            OP_DELETE: begin
                for (int unsigned i = 0; i < N; i++) begin
                    if (!found && vld_q[i] && key_q[i] == i_cmd_key) begin
                        pivot[i] = 1'b1;
                        found    = 1'b1;
                    end
                end
            end
            OP_POP:  pivot[0] = vld_q[0];
            default: pivot = '0;
        endcase
    end

    // Removed-entry mux and shifted storage image for the pending command.
    always_comb begin
        // One-hot pivot minus one, inverted, marks the pivot and everything above it.
        at_or_above = ~(pivot - 1'b1);
        sel_key     = '0;
        sel_val     = '0;
        for (int unsigned i = 0; i < N; i++) begin
            sel_key = sel_key | ({KEY_W{pivot[i]}} & key_q[i]);
            sel_val = sel_val | ({VAL_W{pivot[i]}} & val_q[i]);
            nxt_key[i] = key_q[i];
            nxt_val[i] = val_q[i];
        end
        if (op == OP_INSERT) begin
            for (int unsigned i = 1; i < N; i++) begin
                if (at_or_above[i]) begin
                    nxt_key[i] = key_q[i-1];
                    nxt_val[i] = val_q[i-1];
                end
            end
            for (int unsigned i = 0; i < N; i++) begin
                if (pivot[i]) begin
                    nxt_key[i] = i_cmd_key;
                    nxt_val[i] = i_cmd_val;
                end
            end
            vld_n = {vld_q[N-2:0], 1'b1};
        end else begin
            for (int unsigned i = 0; i + 1 < N; i++) begin
                if (at_or_above[i]) begin
                    nxt_key[i] = key_q[i+1];
                    nxt_val[i] = val_q[i+1];
                end
            end
            vld_n = {1'b0, vld_q[N-1:1]};
        end
    end

    // Response contents for the pending command.
    always_comb begin
        rsp_hit_n = |pivot;
        rsp_key_n = i_cmd_key;
        rsp_val_n = i_cmd_val;
        case (op)
            OP_INSERT: ;
            OP_DELETE: begin
                rsp_key_n = rsp_hit_n ? sel_key : i_cmd_key;
                rsp_val_n = sel_val;
            end
            OP_POP: begin
                rsp_key_n = sel_key;
                rsp_val_n = sel_val;
            end
            default: begin
                rsp_hit_n = 1'b0;
                rsp_key_n = '0;
                rsp_val_n = '0;
            end
        endcase
    end

    // Key/payload storage; contents beyond the valid region are don't-care.
    always_ff @(posedge clk) begin
        if (change) begin
            for (int unsigned i = 0; i < N; i++) begin
                key_q[i] <= nxt_key[i];
                val_q[i] <= nxt_val[i];
            end
        end
    end

    // Validity vector and the occupancy flags that track it.
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            vld_q   <= '0;
            o_cnt   <= '0;
            o_full  <= 1'b0;
            o_empty <= 1'b1;
        end else if (change) begin
            vld_q   <= vld_n;
            o_cnt   <= (op == OP_INSERT) ? o_cnt + 1'b1 : o_cnt - 1'b1;
            o_full  <= vld_n[N-1];
            o_empty <= !vld_n[0];
        end
    end

    // Response FSM: load on accept, hold while the consumer stalls.
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            rsp_state <= RSP_IDLE;
            o_rsp_vld <= 1'b0;
            o_rsp_hit <= 1'b0;
            o_rsp_key <= '0;
            o_rsp_val <= '0;
        end else begin
            case (rsp_state)
                RSP_IDLE: begin
                    if (accept) begin
                        rsp_state <= RSP_VLD;
                        o_rsp_vld <= 1'b1;
                        o_rsp_hit <= rsp_hit_n;
                        o_rsp_key <= rsp_key_n;
                        o_rsp_val <= rsp_val_n;
                    end
                end
                RSP_VLD: begin
                    if (accept) begin
                        o_rsp_hit <= rsp_hit_n;
                        o_rsp_key <= rsp_key_n;
                        o_rsp_val <= rsp_val_n;
                    end else if (i_rsp_rdy) begin
                        rsp_state <= RSP_IDLE;
                        o_rsp_vld <= 1'b0;
                    end
                end
                default: begin
                    rsp_state <= RSP_IDLE;
                    o_rsp_vld <= 1'b0;
                end
            endcase
        end
    end

    // Validity must stay a thermometer code anchored at entry 0.
    a_vld_thermometer: assert property (@(posedge clk) disable iff (arst)
        ((vld_q & (vld_q + 1'b1)) == '0));

endmodule

// File: tb/tb_sorted_tbl.sv
// tb_sorted_tbl: directed stimulus against a queue-based sorted-table model.
module tb_sorted_tbl;

    localparam int N     = 8;
    localparam int KEY_W = 16;
    localparam int VAL_W = 32;
    localparam int CW    = $clog2(N+1);

    logic             clk;
    logic             arst;
    logic             i_cmd_vld;
    logic [1:0]       i_cmd_op;
    logic [KEY_W-1:0] i_cmd_key;
    logic [VAL_W-1:0] i_cmd_val;
    logic             o_cmd_rdy;
    logic             o_rsp_vld;
    logic             i_rsp_rdy;
    logic             o_rsp_hit;
    logic [KEY_W-1:0] o_rsp_key;
    logic [VAL_W-1:0] o_rsp_val;
    logic             o_full;
    logic             o_empty;
    logic [CW-1:0]    o_cnt;

    sorted_tbl #(.N(N), .KEY_W(KEY_W), .VAL_W(VAL_W)) dut (
        .clk       (clk),
        .arst      (arst),
        .i_cmd_vld (i_cmd_vld),
        .i_cmd_op  (i_cmd_op),
        .i_cmd_key (i_cmd_key),
        .i_cmd_val (i_cmd_val),
        .o_cmd_rdy (o_cmd_rdy),
        .o_rsp_vld (o_rsp_vld),
        .i_rsp_rdy (i_rsp_rdy),
        .o_rsp_hit (o_rsp_hit),
        .o_rsp_key (o_rsp_key),
        .o_rsp_val (o_rsp_val),
        .o_full    (o_full),
        .o_empty   (o_empty),
        .o_cnt     (o_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [VAL_W-1:0] vfn(input logic [KEY_W-1:0] k);
        return 32'hC0DE_0000 | VAL_W'(k);
    endfunction

    // Model: sorted queues plus the expected response register.
    logic [KEY_W-1:0] mk[$];
    logic [VAL_W-1:0] mv[$];
    logic             e_vld;
    logic             e_hit;
    logic [KEY_W-1:0] e_key;
    logic [VAL_W-1:0] e_val;

    task automatic model_cmd(input logic [1:0] op, input logic [KEY_W-1:0] k,
                             input logic [VAL_W-1:0] v);
        int pos;
        e_vld = 1'b1;
        e_hit = 1'b0;
        e_key = '0;
        e_val = '0;
        case (op)
            2'd0: begin
                e_key = k;
                e_val = v;
                if (mk.size() < N) begin
                    pos = 0;
                    while (pos < mk.size() && mk[pos] <= k) pos++;
                    mk.insert(pos, k);
                    mv.insert(pos, v);
                    e_hit = 1'b1;
                end
            end
            2'd1: begin
                pos = -1;
                for (int i = 0; i < mk.size(); i++)
                    if (pos < 0 && mk[i] == k) pos = i;
                if (pos >= 0) begin
                    e_hit = 1'b1;
                    e_key = mk[pos];
                    e_val = mv[pos];
                    mk.delete(pos);
                    mv.delete(pos);
                end else begin
                    e_key = k;
                end
            end
            2'd2: begin
                if (mk.size() > 0) begin
                    e_hit = 1'b1;
                    e_key = mk.pop_front();
                    e_val = mv.pop_front();
                end
            end
            default: ;
        endcase
    endtask

    // Compare process: check outputs, then apply this cycle's handshakes to the model.
    always @(negedge clk) begin
        logic [63:0] exp_v;
        logic [63:0] act_v;
        cyc++;
        if (arst) begin
            mk.delete();
            mv.delete();
            e_vld = 1'b0;
            e_hit = 1'b0;
            e_key = '0;
            e_val = '0;
            act_v = 64'({o_rsp_vld, o_rsp_hit, o_rsp_key, o_rsp_val, o_cmd_rdy, o_full, o_empty, o_cnt});
            exp_v = 64'({1'b0, 1'b0, 16'h0, 32'h0, 1'b1, 1'b0, 1'b1, CW'(0)});
            chk("reset_state", act_v, exp_v);
        end else begin
            chk("occupancy", 64'({o_full, o_empty, o_cnt}),
                64'({mk.size() == N, mk.size() == 0, CW'(mk.size())}));
            chk("cmd_rdy", 64'(o_cmd_rdy), 64'(!e_vld || i_rsp_rdy));
            chk("rsp_vld", 64'(o_rsp_vld), 64'(e_vld));
            if (e_vld)
                chk("rsp_fields", 64'({o_rsp_hit, o_rsp_key, o_rsp_val}),
                    64'({e_hit, e_key, e_val}));
            if (i_cmd_vld && (!e_vld || i_rsp_rdy))
                model_cmd(i_cmd_op, i_cmd_key, i_cmd_val);
            else if (i_rsp_rdy)
                e_vld = 1'b0;
        end
    end

    // Drive one command and return 1ns after the edge that accepts it.
    task automatic cmd(input logic [1:0] op, input logic [KEY_W-1:0] k,
                       input logic [VAL_W-1:0] v);
        int budget = 0;
        i_cmd_vld = 1'b1;
        i_cmd_op  = op;
        i_cmd_key = k;
        i_cmd_val = v;
        @(negedge clk);
        while (!o_cmd_rdy && budget < 50) begin
            budget++;
            @(negedge clk);
        end
        if (!o_cmd_rdy) chk("cmd_accept_timeout", 64'(o_cmd_rdy), 64'd1);
        @(posedge clk);
        #1;
        i_cmd_vld = 1'b0;
    endtask

    task automatic expect_rsp(input string name, input logic hit,
                              input logic [KEY_W-1:0] k, input logic [VAL_W-1:0] v);
        @(negedge clk);
        chk(name, 64'({o_rsp_vld, o_rsp_hit, o_rsp_key, o_rsp_val}), 64'({1'b1, hit, k, v}));
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        int start;
        arst      = 1'b1;
        i_cmd_vld = 1'b0;
        i_cmd_op  = 2'd0;
        i_cmd_key = '0;
        i_cmd_val = '0;
        i_rsp_rdy = 1'b1;
        repeat (3) @(negedge clk);
        #2 arst = 1'b0;
        @(posedge clk);
        #1;
        chk("reset_cnt", 64'(o_cnt), 64'd0);
        chk("reset_empty", 64'(o_empty), 64'd1);

        // Out-of-order inserts land sorted.
        cmd(2'd0, 16'd5, vfn(5));  expect_rsp("ins5", 1'b1, 16'd5, vfn(5));
        cmd(2'd0, 16'd2, vfn(2));  expect_rsp("ins2", 1'b1, 16'd2, vfn(2));
        cmd(2'd0, 16'd9, vfn(9));  expect_rsp("ins9", 1'b1, 16'd9, vfn(9));
        chk("cnt_3", 64'(o_cnt), 64'd3);
        chk("model_k0", 64'(mk[0]), 64'd2);
        chk("model_k1", 64'(mk[1]), 64'd5);
        chk("model_k2", 64'(mk[2]), 64'd9);

        // Delete hit and miss.
        cmd(2'd1, 16'd5, '0);      expect_rsp("del5", 1'b1, 16'd5, vfn(5));
        chk("cnt_2", 64'(o_cnt), 64'd2);
        chk("model_after_del", 64'({mk[0], mk[1]}), 64'({16'd2, 16'd9}));
        cmd(2'd1, 16'd7, '0);      expect_rsp("del7_miss", 1'b0, 16'd7, 32'd0);
        cmd(2'd2, '0, '0);         expect_rsp("pop2", 1'b1, 16'd2, vfn(2));
        cmd(2'd2, '0, '0);         expect_rsp("pop9", 1'b1, 16'd9, vfn(9));
        cmd(2'd2, '0, '0);         expect_rsp("pop_empty", 1'b0, 16'd0, 32'd0);
        chk("empty_after_pops", 64'(o_empty), 64'd1);

        // Equal keys pop in insertion order.
        cmd(2'd0, 16'd4, 32'h1111_AAAA); expect_rsp("ins4a", 1'b1, 16'd4, 32'h1111_AAAA);
        cmd(2'd0, 16'd4, 32'h2222_BBBB); expect_rsp("ins4b", 1'b1, 16'd4, 32'h2222_BBBB);
        cmd(2'd2, '0, '0);         expect_rsp("pop_tie_a", 1'b1, 16'd4, 32'h1111_AAAA);
        cmd(2'd2, '0, '0);         expect_rsp("pop_tie_b", 1'b1, 16'd4, 32'h2222_BBBB);
        cmd(2'd2, '0, '0);         expect_rsp("pop_tie_empty", 1'b0, 16'd0, 32'd0);
        chk("empty_after_ties", 64'(o_empty), 64'd1);

        // Reserved opcode.
        cmd(2'd3, 16'd123, 32'd456); expect_rsp("nop", 1'b0, 16'd0, 32'd0);

        // Fill with descending keys, then overflow insert.
        for (int i = 0; i < N; i++) begin
            cmd(2'd0, 16'(80 - 10 * i), vfn(16'(80 - 10 * i)));
            expect_rsp("ins_fill", 1'b1, 16'(80 - 10 * i), vfn(16'(80 - 10 * i)));
        end
        chk("full_flag", 64'(o_full), 64'd1);
        cmd(2'd0, 16'd1, 32'hDEAD_0001); expect_rsp("ins_full", 1'b0, 16'd1, 32'hDEAD_0001);
        chk("full_cnt", 64'(o_cnt), 64'd8);
        chk("model_full_head", 64'(mk[0]), 64'd10);
        cmd(2'd2, '0, '0);         expect_rsp("pop_full_head", 1'b1, 16'd10, vfn(10));

        // Back-to-back drain, one accept per cycle.
        start = cyc;
        for (int i = 0; i < N - 1; i++) cmd(2'd2, '0, '0);
        chk("b2b_cycles", 64'(cyc - start), 64'd7);
        @(posedge clk);
        #1;
        chk("drained", 64'(o_empty), 64'd1);

        // Consumer stall: response held, no new accept.
        i_rsp_rdy = 1'b0;
        cmd(2'd0, 16'd50, vfn(50));
        i_cmd_vld = 1'b1;
        i_cmd_op  = 2'd0;
        i_cmd_key = 16'd60;
        i_cmd_val = vfn(60);
        repeat (3) begin
            @(negedge clk);
            chk("hold_cmd_rdy", 64'(o_cmd_rdy), 64'd0);
            chk("hold_rsp", 64'({o_rsp_vld, o_rsp_key, o_rsp_val}), 64'({1'b1, 16'd50, vfn(50)}));
        end
        @(posedge clk);
        #1;
        i_rsp_rdy = 1'b1;
        cmd(2'd0, 16'd60, vfn(60)); expect_rsp("ins60_after_hold", 1'b1, 16'd60, vfn(60));

        // Async reset while a response is pending.
        cmd(2'd0, 16'd70, vfn(70));
        cmd(2'd0, 16'd20, vfn(20));
        chk("pre_reset", 64'({o_rsp_vld, o_cnt}), 64'({1'b1, CW'(4)}));
        #2 arst = 1'b1;
        #1;
        chk("async_reset", 64'({o_rsp_vld, o_cnt, o_empty}), 64'({1'b0, CW'(0), 1'b1}));
        @(negedge clk);
        #2 arst = 1'b0;
        @(posedge clk);
        #1;
        cmd(2'd0, 16'd3, vfn(3));  expect_rsp("ins_after_reset", 1'b1, 16'd3, vfn(3));
        chk("cnt_after_reset", 64'(o_cnt), 64'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
